// File: rtl/sccb_config_sequencer.sv
// Camera register-table sequencer: walks a fixed ROM and issues one SCCB write per entry,
// handshaking on sccb_ready and honouring inline delay / end markers.
module sccb_config_sequencer #(
  parameter int unsigned CLK_FREQ     = 25_000_000,
  parameter int unsigned DELAY_CYCLES = 250_000,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       config_start,
  input  logic       sccb_ready,
  output logic       sccb_start,
  output logic [7:0] sccb_address,
  output logic [7:0] sccb_data,
  output logic       config_busy,
  output logic       config_done,
  output logic [3:0] config_index
);

  localparam int unsigned CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  if (DELAY_CYCLES < 1 || CLK_FREQ == 0) begin : g_param_check
    $error("sccb_config_sequencer: DELAY_CYCLES must be >= 1 and CLK_FREQ nonzero");
  end

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE,
    DELAY,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] delay_cnt;
  logic             auto_pending;
  logic [15:0]      entry;

  // Indices past the table decode as the end marker.
  always_comb begin
    entry = 16'hFFFF;
    case (config_index)
      4'd0:    entry = 16'h1280;
      4'd1:    entry = 16'hFFF0;
      4'd2:    entry = 16'h1204;
      4'd3:    entry = 16'h1101;
      4'd4:    entry = 16'h40D0;
      4'd5:    entry = 16'h3A04;
      4'd6:    entry = 16'h8C00;
      default: entry = 16'hFFFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      sccb_start   <= 1'b0;
      sccb_address <= '0;
      sccb_data    <= '0;
      config_busy  <= 1'b0;
      config_done  <= 1'b0;
      config_index <= '0;
      delay_cnt    <= '0;
      auto_pending <= AUTO_START;
    end else begin
      sccb_start <= 1'b0;
      case (state)
        IDLE: begin
          // auto_pending turns the first post-reset cycle into an implicit start.
          if (config_start || auto_pending) begin
            auto_pending <= 1'b0;
            config_index <= '0;
            config_done  <= 1'b0;
            config_busy  <= 1'b1;
            state        <= FETCH;
          end
        end
        FETCH: begin
          if (entry == 16'hFFFF) begin
            state <= DONE;
          end else if (entry == 16'hFFF0) begin
            delay_cnt <= CNT_W'(DELAY_CYCLES - 1);
            state     <= DELAY;
          end else begin
            sccb_address <= entry[15:8];
            sccb_data    <= entry[7:0];
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (sccb_ready) begin
            sccb_start <= 1'b1;
            state      <= WAIT_ACCEPT;
          end
        end
        WAIT_ACCEPT: begin
          if (!sccb_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (sccb_ready) begin
            config_index <= config_index + 4'd1;
            state        <= FETCH;
          end
        end
        DELAY: begin
          if (delay_cnt == '0) begin
            config_index <= config_index + 4'd1;
            state        <= FETCH;
          end else begin
            delay_cnt <= delay_cnt - 1'b1;
          end
        end
        DONE: begin
          config_busy <= 1'b0;
          config_done <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench: two sequencers (auto-start and manual) driven by a simple SCCB ready model.
module tb_sccb_config_sequencer;

  localparam int unsigned DLY  = 20;
  localparam int unsigned BUSY = 50;
  localparam logic [15:0] EXP [6] = '{16'h1280, 16'h1204, 16'h1101, 16'h40D0, 16'h3A04, 16'h8C00};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        cfg_start [2];
  logic        force_low [2];
  int unsigned hold      [2];
  int unsigned t         [2];
  logic        rdy       [2];
  logic        st        [2];
  logic [7:0]  addr      [2];
  logic [7:0]  data      [2];
  logic        busy      [2];
  logic        done      [2];
  logic [3:0]  idx       [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] wlog [2][64];
  int          gap  [2][64];
  int          wcnt      [2];
  int          last_rise [2];
  int          done_gap  [2];
  int          run_len   [2];
  logic        prev_rdy  [2];
  logic        prev_done [2];

  sccb_config_sequencer #(.DELAY_CYCLES(DLY), .AUTO_START(1'b1)) dut_auto (
    .clk(clk), .reset(rst[0]), .config_start(cfg_start[0]), .sccb_ready(rdy[0]),
    .sccb_start(st[0]), .sccb_address(addr[0]), .sccb_data(data[0]),
    .config_busy(busy[0]), .config_done(done[0]), .config_index(idx[0])
  );

  sccb_config_sequencer #(.DELAY_CYCLES(DLY), .AUTO_START(1'b0)) dut_manual (
    .clk(clk), .reset(rst[1]), .config_start(cfg_start[1]), .sccb_ready(rdy[1]),
    .sccb_start(st[1]), .sccb_address(addr[1]), .sccb_data(data[1]),
    .config_busy(busy[1]), .config_done(done[1]), .config_index(idx[1])
  );

  // SCCB model: ready stays high hold[i] cycles after the start pulse, then low for BUSY cycles.
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (!rst[i])         t[i] <= 0;
      else if (st[i])      t[i] <= hold[i] + BUSY;
      else if (t[i] != 0)  t[i] <= t[i] - 1;
    end

  assign rdy[0] = !force_low[0] && (t[0] == 0 || t[0] > BUSY);
  assign rdy[1] = !force_low[1] && (t[1] == 0 || t[1] > BUSY);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      wcnt[i] = 0; last_rise[i] = 0; done_gap[i] = -1; run_len[i] = 0;
      prev_rdy[i] = 1'b0; prev_done[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rdy[i] && !prev_rdy[i]) last_rise[i] = cyc;
        prev_rdy[i] = rdy[i];
        if (done[i] === 1'b1 && prev_done[i] !== 1'b1) done_gap[i] = cyc - last_rise[i];
        prev_done[i] = done[i];
        run_len[i] = (st[i] === 1'b1) ? run_len[i] + 1 : 0;
        if (st[i] === 1'b1) begin
          check("start_width", run_len[i], 1);
          check("start_while_ready", rdy[i], 1);
          if (wcnt[i] < 64) begin
            wlog[i][wcnt[i]] = {addr[i], data[i]};
            gap[i][wcnt[i]]  = cyc - last_rise[i];
          end
          wcnt[i]++;
        end
      end
    end
  end

  task automatic pulse_start(input int i);
    @(posedge clk); #1 cfg_start[i] = 1'b1;
    @(posedge clk); #1 cfg_start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    @(negedge clk);
    while (done[i] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", done[i], 1);
  endtask

  task automatic wait_writes(input int i, input int target, input int budget);
    int n = 0;
    while (wcnt[i] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("write_timeout", wcnt[i], target);
  endtask

  task automatic check_run(input int i, input int base);
    check("write_count", wcnt[i], base + 6);
    for (int k = 0; k < 6; k++) check($sformatf("write%0d_pair", k), wlog[i][base + k], EXP[k]);
    check("delay_gap", gap[i][base + 1], DLY + 4);
    for (int k = 2; k < 6; k++) check($sformatf("write%0d_gap", k), gap[i][base + k], 3);
    check("done_gap", done_gap[i], 3);
    check("busy_after", busy[i], 0);
    check("index_end", idx[i], 7);
    check("hold_pair", {addr[i], data[i]}, 16'h8C00);
  endtask

  task automatic check_reset(input int i);
    check("rst_start", st[i], 0);
    check("rst_pair", {addr[i], data[i]}, 0);
    check("rst_busy", busy[i], 0);
    check("rst_done", done[i], 0);
    check("rst_index", idx[i], 0);
  endtask

  initial begin
    int c0;
    rst       = '{1'b0, 1'b0};
    cfg_start = '{1'b0, 1'b0};
    force_low = '{1'b0, 1'b0};
    hold      = '{1, 1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    @(posedge clk); #1 rst = '{1'b1, 1'b1};
    repeat (2) @(negedge clk);
    check("auto_busy", busy[0], 1);
    check("manual_idle", busy[1], 0);

    // Auto-start run with delay marker timing
    wait_done(0, 3000);
    check_run(0, 0);
    check("manual_no_writes", wcnt[1], 0);
    check("manual_not_done", done[1], 0);

    // Manual instance: stall in ISSUE with ready low
    @(posedge clk); #1 force_low[1] = 1'b1;
    pulse_start(1);
    repeat (100) @(negedge clk);
    check("stall_no_start", wcnt[1], 0);
    check("stall_busy", busy[1], 1);
    check("stall_latched", {addr[1], data[1]}, 16'h1280);
    @(posedge clk); #1 force_low[1] = 1'b0;
    c0 = cyc;
    wait_writes(1, 1, 10);
    check("stall_release_lat", cyc - c0, 1);

    // Start request mid-run is ignored
    repeat (100) @(negedge clk);
    pulse_start(1);
    wait_done(1, 3000);
    repeat (5) @(negedge clk);
    check_run(1, 0);
    check("ignored_restart", wcnt[1], 6);

    // Restart after done
    pulse_start(1);
    @(negedge clk);
    check("restart_done_clr", done[1], 0);
    check("restart_busy", busy[1], 1);
    wait_done(1, 3000);
    check_run(1, 6);

    // Ready held high after start: no duplicate write
    hold[0] = 3;
    pulse_start(0);
    wait_done(0, 3000);
    check("hold_write_count", wcnt[0], 12);
    for (int k = 0; k < 6; k++) check($sformatf("hold_write%0d", k), wlog[0][6 + k], EXP[k]);

    // Reset while a write is in flight, then auto restart
    hold[0] = 1;
    pulse_start(0);
    wait_writes(0, 13, 500);
    repeat (10) @(negedge clk);
    check("inflight_ready_low", rdy[0], 0);
    @(posedge clk); #1 rst[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset(0);
    @(posedge clk); #1 rst[0] = 1'b1;
    wait_writes(0, 14, 100);
    check("restart_pair", wlog[0][13], 16'h1280);
    check("restart_index", idx[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
